// File: rtl/parity_game_ctrl.sv
// Parity game controller.
// The player loads a 16-bit word arranged as a 4x4 grid. The block can then
// inject a single-bit error at a pseudo-random position, and the player asks
// for a correction. The correction uses the row/column parity syndrome. The
// round scores as a success only when the corrected word matches the word
// that was loaded.
//
// Key handshake: each key is an active-low level input. It is synchronised
// and turned into a single-cycle pulse on its press (falling edge). When
// several pulses land on the same cycle, only the highest-priority one is
// consumed (load > inject > correct) and the rest are discarded.
module parity_game_ctrl #(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic        key_inject,
  input  logic        key_correct,
  input  logic [15:0] sw,
  output logic [15:0] num,
  output logic [3:0]  err_idx,
  output logic        err_valid,
  output logic [4:0]  fix_idx,
  output logic [2:0]  state,
  output logic        done,
  output logic [7:0]  score
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOADED    = 3'd1,
    S_INJECTED  = 3'd2,
    S_ARMED     = 3'd3,
    S_CORRECTED = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  // ---------------------------------------------------------------------
  // Key conditioning: bit 2 = load, bit 1 = inject, bit 0 = correct
  // ---------------------------------------------------------------------
  logic [2:0] keys;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [1:0] settle;
  logic [2:0] fall;
  logic       load_p;
  logic       inject_p;
  logic       correct_p;

  assign keys = {key_load, key_inject, key_correct};

  // Two-flop synchroniser, edge-history flop and post-reset settle counter.
  // Until the pipeline has refilled with real key levels, no pulse is
  // allowed. Without this, a key held low through reset would look like
  // a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 3'b111;
      sync2  <= 3'b111;
      prev   <= 3'b111;
      settle <= 2'd0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      prev  <= sync2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign fall      = (settle == 2'd3) ? (prev & ~sync2) : 3'b000;
  assign load_p    = fall[2];
  assign inject_p  = fall[1] & ~fall[2];
  assign correct_p = fall[0] & ~fall[2] & ~fall[1];

  // ---------------------------------------------------------------------
  // 4-bit LFSR for the inject position (x^4 + x^3 + 1, never zero)
  // ---------------------------------------------------------------------
  logic [3:0] lfsr;

  // Free-running LFSR that advances every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 4'b0001;
    else     lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  // ---------------------------------------------------------------------
  // Parity helpers: bit index is 4*row + col
  // ---------------------------------------------------------------------
  function automatic logic [3:0] row_parity(input logic [15:0] w);
    logic [3:0] p;
    for (int r = 0; r < 4; r++) p[r] = ^w[4*r +: 4];
    return p;
  endfunction

  function automatic logic [3:0] col_parity(input logic [15:0] w);
    logic [3:0] p;
    for (int c = 0; c < 4; c++) p[c] = w[c] ^ w[c+4] ^ w[c+8] ^ w[c+12];
    return p;
  endfunction

  function automatic logic one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] e;
    e = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) e = 2'(i);
    return e;
  endfunction

  // ---------------------------------------------------------------------
  // Datapath registers and syndrome
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [15:0]   num_q, num_d;
  logic [15:0]   golden_q, golden_d;
  logic [3:0]    row_par_q, row_par_d;
  logic [3:0]    col_par_q, col_par_d;
  logic [3:0]    err_idx_q, err_idx_d;
  logic          err_valid_q, err_valid_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    score_q, score_d;
  logic [4:0]    fix_q;
  logic [4:0]    fix_next;
  logic [3:0]    row_mis;
  logic [3:0]    col_mis;
  logic [15:0]   corrected;

  assign row_mis = row_parity(num_q) ^ row_par_q;
  assign col_mis = col_parity(num_q) ^ col_par_q;

  // Map the syndrome to a single bit index, or 16 when it is not a clean
  // single-bit error.
  always_comb begin
    fix_next = 5'd16;
    if (one_hot(row_mis) && one_hot(col_mis))
      fix_next = {1'b0, enc4(row_mis), enc4(col_mis)};
  end

  // The syndrome index is registered, so it trails num by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fix_q <= 5'd16;
    else     fix_q <= fix_next;
  end

  assign corrected = fix_q[4] ? num_q : (num_q ^ (16'h0001 << fix_q[3:0]));

  // ---------------------------------------------------------------------
  // Game FSM: next state and datapath updates
  // ---------------------------------------------------------------------
  // A load is accepted in every state. The other events only apply in the
  // single state that expects them.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    golden_d    = golden_q;
    row_par_d   = row_par_q;
    col_par_d   = col_par_q;
    err_idx_d   = err_idx_q;
    err_valid_d = err_valid_q;
    timer_d     = timer_q;
    score_d     = score_q;
    if (load_p) begin
      num_d       = sw;
      golden_d    = sw;
      row_par_d   = row_parity(sw);
      col_par_d   = col_parity(sw);
      err_valid_d = 1'b0;
      timer_d     = '0;
      state_d     = S_LOADED;
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_LOADED: begin
          if (inject_p) begin
            num_d       = num_q ^ (16'h0001 << lfsr);
            err_idx_d   = lfsr;
            err_valid_d = 1'b1;
            state_d     = S_INJECTED;
          end
        end
        S_INJECTED: begin
          // One cycle lets the registered syndrome catch up with the flip.
          timer_d = '0;
          state_d = S_ARMED;
        end
        S_ARMED: begin
          if (correct_p) begin
            num_d = corrected;
            if (corrected == golden_q) begin
              state_d = S_CORRECTED;
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end else begin
              state_d = S_FAIL;
            end
          end else if (timer_q == T_LAST) begin
            state_d = S_FAIL;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_CORRECTED, S_FAIL: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Register the FSM state and every datapath field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= 16'd0;
      golden_q    <= 16'd0;
      row_par_q   <= 4'd0;
      col_par_q   <= 4'd0;
      err_idx_q   <= 4'd0;
      err_valid_q <= 1'b0;
      timer_q     <= '0;
      score_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      golden_q    <= golden_d;
      row_par_q   <= row_par_d;
      col_par_q   <= col_par_d;
      err_idx_q   <= err_idx_d;
      err_valid_q <= err_valid_d;
      timer_q     <= timer_d;
      score_q     <= score_d;
    end
  end

  assign num       = num_q;
  assign err_idx   = err_idx_q;
  assign err_valid = err_valid_q;
  assign fix_idx   = fix_q;
  assign state     = state_q;
  assign done      = (state_q == S_CORRECTED) || (state_q == S_FAIL);
  assign score     = score_q;

endmodule

// File: tb/tb_parity_game_ctrl.sv
// Directed bench for parity_game_ctrl. One instance uses the default
// timeout. A second instance uses an 8-cycle timeout and shares the same
// stimulus.
module tb_parity_game_ctrl;

  logic        clk;
  logic        rst;
  logic        key_load;
  logic        key_inject;
  logic        key_correct;
  logic [15:0] sw;

  logic [15:0] num,    to_num;
  logic [3:0]  err_idx, to_err_idx;
  logic        err_valid, to_err_valid;
  logic [4:0]  fix_idx, to_fix_idx;
  logic [2:0]  state,  to_state;
  logic        done,   to_done;
  logic [7:0]  score,  to_score;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] lfsr_m;

  parity_game_ctrl dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_inject(key_inject),
    .key_correct(key_correct), .sw(sw), .num(num), .err_idx(err_idx),
    .err_valid(err_valid), .fix_idx(fix_idx), .state(state), .done(done),
    .score(score)
  );

  parity_game_ctrl #(.TIMEOUT_CYC(8)) dut_to (
    .clk(clk), .rst(rst), .key_load(key_load), .key_inject(key_inject),
    .key_correct(key_correct), .sw(sw), .num(to_num), .err_idx(to_err_idx),
    .err_valid(to_err_valid), .fix_idx(to_fix_idx), .state(to_state),
    .done(to_done), .score(to_score)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR for x^4 + x^3 + 1, seeded at 1 by reset.
  function automatic logic [3:0] lfsr_step(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  // Track the expected LFSR position so inject indices can be planned.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 4'b0001;
    else     lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mask bits: 2 = load, 1 = inject, 0 = correct. The event lands on the
  // third rising edge after the press, so the outputs are checked after that.
  task automatic key_down(input logic [2:0] mask);
    key_load    = ~mask[2];
    key_inject  = ~mask[1];
    key_correct = ~mask[0];
    repeat (3) @(negedge clk);
  endtask

  task automatic key_up();
    key_load    = 1'b1;
    key_inject  = 1'b1;
    key_correct = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Wait until a press made now would inject at bit 'target'.
  task automatic wait_lfsr(input logic [3:0] target);
    int  cnt;
    logic hit;
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < 20) begin
      if (lfsr_step(lfsr_step(lfsr_m)) == target) hit = 1'b1;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    check("lfsr_reach", {31'd0, hit}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    key_load = 1'b1;
    key_inject = 1'b1;
    key_correct = 1'b1;
    sw = 16'hA5C3;
    repeat (2) @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_num", num, 16'h0000);
    check("rst_fix", fix_idx, 5'd16);
    check("rst_score", score, 8'd0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Load A5C3.
    key_down(3'b100);
    check("load_state", state, 3'd1);
    check("load_num", num, 16'hA5C3);
    check("load_errv", err_valid, 1'b0);
    check("load_fix0", fix_idx, 5'd16);
    @(negedge clk);
    check("load_fix1", fix_idx, 5'd16);
    key_up();

    // Inject at bit 6, then correct it.
    wait_lfsr(4'd6);
    key_down(3'b010);
    check("inj_state", state, 3'd2);
    check("inj_num", num, 16'hA583);
    check("inj_idx", err_idx, 4'd6);
    check("inj_errv", err_valid, 1'b1);
    check("inj_fix_lag", fix_idx, 5'd16);
    @(negedge clk);
    check("armed_state", state, 3'd3);
    check("armed_fix", fix_idx, 5'd6);
    key_up();
    key_down(3'b001);
    check("cor_num", num, 16'hA5C3);
    check("cor_state", state, 3'd4);
    check("cor_done", done, 1'b1);
    check("cor_score", score, 8'd1);
    key_up();
    check("cor_fix_clear", fix_idx, 5'd16);

    // Timeout on the 8-cycle instance.
    key_down(3'b100);
    key_up();
    wait_lfsr(4'd6);
    key_down(3'b010);
    check("to_inj_state", to_state, 3'd2);
    key_load = 1'b1;
    key_inject = 1'b1;
    key_correct = 1'b1;
    @(negedge clk);
    check("to_armed", to_state, 3'd3);
    repeat (7) @(negedge clk);
    check("to_still_armed", to_state, 3'd3);
    @(negedge clk);
    check("to_fail", to_state, 3'd5);
    check("to_num_kept", to_num, 16'hA583);
    check("to_done", to_done, 1'b1);

    // An inject while armed is ignored.
    check("ign_pre_state", state, 3'd3);
    wait_lfsr(4'd9);
    key_down(3'b010);
    check("ign_state", state, 3'd3);
    check("ign_idx", err_idx, 4'd6);
    check("ign_fix", fix_idx, 5'd6);
    check("ign_num", num, 16'hA583);
    key_up();

    // Load and correct pressed together: load wins.
    sw = 16'h1234;
    key_down(3'b101);
    check("pri_state", state, 3'd1);
    check("pri_num", num, 16'h1234);
    check("pri_score", score, 8'd1);
    check("pri_errv", err_valid, 1'b0);
    check("pri_done", done, 1'b0);
    key_up();
    check("pri_fix", fix_idx, 5'd16);

    // A correct in LOADED is ignored; then inject at bit 3.
    key_down(3'b001);
    check("cor_ign_state", state, 3'd1);
    check("cor_ign_num", num, 16'h1234);
    key_up();
    wait_lfsr(4'd3);
    key_down(3'b010);
    check("inj3_num", num, 16'h123C);
    check("inj3_idx", err_idx, 4'd3);
    @(negedge clk);
    check("inj3_fix", fix_idx, 5'd3);
    key_up();

    // Reset while armed, with load held across the reset release.
    check("pre_rst_state", state, 3'd3);
    key_load = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_num", num, 16'h0000);
    check("mid_rst_idx", err_idx, 4'd0);
    check("mid_rst_errv", err_valid, 1'b0);
    check("mid_rst_fix", fix_idx, 5'd16);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_score", score, 8'd0);
    check("mid_rst_to_state", to_state, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("held_key_no_pulse", state, 3'd0);
    key_up();
    key_down(3'b010);
    check("idle_ign_inject", state, 3'd0);
    check("idle_ign_num", num, 16'h0000);
    key_up();

    // Saturate the score.
    for (int i = 0; i < 255; i++) begin
      key_down(3'b100);
      key_up();
      key_down(3'b010);
      key_up();
      key_down(3'b001);
      key_up();
    end
    check("score_255", score, 8'd255);
    key_down(3'b100);
    key_up();
    key_down(3'b010);
    key_up();
    key_down(3'b001);
    check("sat_state", state, 3'd4);
    check("sat_score", score, 8'd255);
    key_up();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
